// File: rtl/crc8_frame_checker.sv
// CRC-8 (poly 0x07) frame checker: strips the trailer byte from each frame,
// forwards the payload with backpressure and reports a per-frame status pulse.
module crc8_frame_checker #(
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  inData,
    input  logic        inValid,
    input  logic        inLast,
    output logic        inReady,
    output logic [7:0]  outData,
    output logic        outValid,
    output logic        outLast,
    input  logic        outReady,
    output logic        statusValid,
    output logic        statusOk,
    output logic        statusRunt,
    output logic [15:0] frameLen
);

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        status_valid_q, status_valid_d;
    logic        status_ok_q, status_ok_d;
    logic        status_runt_q, status_runt_d;
    logic [15:0] frame_len_q, frame_len_d;

    logic        accept;
    logic [7:0]  crc_next;
    logic [15:0] cnt_inc;

    assign inReady  = !out_valid_q || outReady;
    assign accept   = inValid && inReady;
    assign crc_next = crc8_byte(crc_q, inData);
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        crc_d          = crc_q;
        cnt_d          = cnt_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        status_valid_d = 1'b0;
        status_ok_d    = status_ok_q;
        status_runt_d  = status_runt_q;
        frame_len_d    = frame_len_q;

        if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end

        // Output register is always free when a byte is accepted.
        if (accept) begin
            if (!inLast) begin
                crc_d       = crc_next;
                hold_d      = inData;
                hold_full_d = 1'b1;
                if (hold_full_q) begin
                    out_data_d  = hold_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    cnt_d       = cnt_inc;
                end
            end else begin
                status_valid_d = 1'b1;
                if (hold_full_q) begin
                    out_data_d    = hold_q;
                    out_valid_d   = 1'b1;
                    out_last_d    = 1'b1;
                    status_ok_d   = (crc_next == 8'h00);
                    status_runt_d = 1'b0;
                    frame_len_d   = cnt_inc;
                end else begin
                    status_ok_d   = 1'b0;
                    status_runt_d = 1'b1;
                    frame_len_d   = 16'd0;
                end
                hold_full_d = 1'b0;
                crc_d       = CRC_INIT;
                cnt_d       = 16'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hold_q         <= 8'h00;
            hold_full_q    <= 1'b0;
            crc_q          <= CRC_INIT;
            cnt_q          <= 16'd0;
            out_data_q     <= 8'h00;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_ok_q    <= 1'b0;
            status_runt_q  <= 1'b0;
            frame_len_q    <= 16'd0;
        end else begin
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            crc_q          <= crc_d;
            cnt_q          <= cnt_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            status_valid_q <= status_valid_d;
            status_ok_q    <= status_ok_d;
            status_runt_q  <= status_runt_d;
            frame_len_q    <= frame_len_d;
        end
    end

    assign outData     = out_data_q;
    assign outValid    = out_valid_q;
    assign outLast     = out_last_q;
    assign statusValid = status_valid_q;
    assign statusOk    = status_ok_q;
    assign statusRunt  = status_runt_q;
    assign frameLen    = frame_len_q;

endmodule

// File: doc/crc8_frame_checker.md
CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001 SHALL have parameter CRC_INIT, default 8'h00, CRC register start value per frame.
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock; all state updates on its rising edge.
- rstN  input  1  reset: asynchronous and active-low.
- inData  input  8  receive byte stream; the last byte of each frame is the CRC-8 trailer.
- inValid  input  1  inData valid.
- inLast  input  1  marks the trailer byte of a frame.
- inReady  output  1  block accepts a byte this cycle.
- outData  output  8  payload byte, trailer stripped.
- outValid  output  1  outData valid.
- outLast  output  1  final payload byte of a frame.
- outReady  input  1  downstream accepts the output byte.
- statusValid  output  1  one-cycle frame-result pulse.
- statusOk  output  1  CRC check passed; valid with statusValid.
- statusRunt  output  1  frame had no payload (trailer only); valid with statusValid.
- frameLen  output  16  payload byte count; valid with statusValid.

Function
REQ-003 SHALL compute CRC-8 with polynomial x^8+x^2+x+1 (0x07), MSB-first left shift, 8 bits per byte, no reflection, no final XOR.
REQ-004 SHALL define an accept event as inValid && inReady at a rising edge; inReady SHALL equal (!outValid || outReady).
REQ-005 SHALL update the running CRC with every accepted byte, including the trailer; the trailer check passes iff the resulting CRC equals 8'h00.
REQ-006 SHALL hold one payload byte in an internal hold register so the trailer can be stripped; hold starts empty at frame start.
REQ-007 On accepting a non-last byte with hold empty: SHALL store it in hold; no output.
REQ-008 On accepting a non-last byte with hold full: SHALL move hold to the output register (outLast=0), store the new byte in hold, and increment the payload count.
REQ-009 On accepting a last byte with hold full: SHALL move hold to the output register with outLast=1 and discard the trailer; status SHALL be reported per REQ-011; then hold empties, CRC resets to CRC_INIT and the count resets to 0 for the next frame.
REQ-010 On accepting a last byte with hold empty (runt frame): SHALL produce no output byte; status SHALL be reported per REQ-011 with statusOk=0, statusRunt=1 and frameLen=0; CRC and count reset as in REQ-009.
REQ-011 SHALL assert statusValid for exactly one cycle, in the cycle after the last-byte accept; statusOk, statusRunt and frameLen SHALL be driven with it and may take any value when statusValid=0. statusValid has no backpressure.
REQ-012 frameLen SHALL equal the number of payload bytes output for that frame and SHALL saturate at 16'hFFFF.
REQ-013 While outValid && !outReady: outData and outLast SHALL hold stable and inReady SHALL be 0. The output register SHALL clear outValid after an output handshake when no new byte is loaded.
REQ-014 Latency: a payload byte SHALL appear on outData one cycle after the accept of the following byte, whether that byte is payload or trailer.
REQ-015 Back-to-back frames SHALL be supported: the first byte of frame N+1 may be accepted in the cycle immediately after the trailer of frame N.

Reset
REQ-016 While rstN=0: outValid=0, outLast=0, outData=0, statusValid=0, statusOk=0, statusRunt=0, frameLen=0, hold empty, CRC=CRC_INIT, count=0; inReady=1 from the first clock edge after release.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame, including any held or output byte, and SHALL emit no status.

Verification
REQ-018 Frame {8'h01, 8'h07} -> outData=8'h01 with outLast=1; statusValid pulse with statusOk=1, statusRunt=0, frameLen=1.
REQ-019 Frame {8'h31..8'h39, 8'hF4} ("123456789") -> outputs 8'h31..8'h39 in order, outLast on 8'h39; statusOk=1, frameLen=9. Corrupting the trailer to 8'hF5 -> same output, statusOk=0.
REQ-020 Single byte 8'h00 with inLast=1 -> no output byte; status pulse with statusOk=0, statusRunt=1, frameLen=0.
REQ-021 outReady held low for 5 cycles mid-frame, inValid held high -> inReady=0 for those cycles, outData stable; no byte lost or duplicated; final status correct.
REQ-022 rstN pulsed low after 3 bytes of a frame, then frame {8'h01, 8'h07} -> no status for the aborted frame; new frame reports statusOk=1, frameLen=1.
REQ-023 Two back-to-back frames {8'h01, 8'h07} and {8'h02, 8'h0E} with inValid high continuously -> two status pulses, both statusOk=1, frameLen=1.
